// File: rtl/gcm_pkg.sv
// Shared GCM output-path constants and the block FIFO entry type.
package gcm_pkg;

  localparam int unsigned GCM_BLK_BITS  = 128;
  localparam int unsigned OUT_BITS      = 32;
  localparam int unsigned WORDS_PER_BLK = GCM_BLK_BITS / OUT_BITS;

  typedef struct packed {
    logic                    last;
    logic [GCM_BLK_BITS-1:0] blk;
  } gcm_fifo_entry_t;

endpackage

// File: rtl/gcm_blk_fifo.sv
// Synchronous block FIFO; a push on a full FIFO is taken only when a pop frees the slot.
module gcm_blk_fifo
  import gcm_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  gcm_fifo_entry_t        i_wdata,
  input  logic                   i_pop,
  output gcm_fifo_entry_t        o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  gcm_fifo_entry_t r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  // Pointers are power-of-two wide, so plain increment wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/gcm_out_stream.sv
// Buffers 128-bit GCM output blocks and serialises them MS word first onto AXI4-Stream.
// Define GCM_OUT_BYTESWAP_EN to byte-reverse each output word for little-endian DMA.
module gcm_out_stream
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned OUT_BITS   = gcm_pkg::OUT_BITS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [gcm_pkg::GCM_BLK_BITS-1:0] gcm_out_blk,
  input  logic                            gcm_out_store_blk,
  input  logic                            gcm_out_last,
  output logic                            hold_off,
  output logic [OUT_BITS-1:0]             m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic                            overflow
);

  import gcm_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  gcm_fifo_entry_t w_wdata;
  gcm_fifo_entry_t w_rdata;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_free;
  logic            w_hs;
  logic            w_pop;
  logic [31:0]     w_word;

  logic [1:0] r_word_cnt;
  logic       r_overflow;

  assign w_wdata.last = gcm_out_last;
  assign w_wdata.blk  = gcm_out_blk;

  gcm_blk_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (gcm_out_store_blk),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign m_axis_tvalid = !w_empty;
  assign w_hs          = m_axis_tvalid && m_axis_tready;
  assign w_pop         = w_hs && (r_word_cnt == 2'd3);

  // Upstream has one cycle of strobe latency, so it must stop with a slot still spare.
  assign w_free   = CW'(FIFO_DEPTH) - w_count;
  assign hold_off = (w_free < CW'(2));

  always_comb begin
    w_word = '0;
    unique case (r_word_cnt)
      2'd0: w_word = w_rdata.blk[127:96];
      2'd1: w_word = w_rdata.blk[95:64];
      2'd2: w_word = w_rdata.blk[63:32];
      2'd3: w_word = w_rdata.blk[31:0];
    endcase
  end

`ifdef GCM_OUT_BYTESWAP_EN
  assign m_axis_tdata = {w_word[7:0], w_word[15:8], w_word[23:16], w_word[31:24]};
`else
  assign m_axis_tdata = w_word;
`endif

  assign m_axis_tlast = m_axis_tvalid && w_rdata.last && (r_word_cnt == 2'd3);
  assign overflow     = r_overflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_word_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_hs) r_word_cnt <= r_word_cnt + 1'b1;
      // A strobe is only dropped when full and no pop frees a slot this cycle.
      if (gcm_out_store_blk && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gcm_out_stream.sv
// Scoreboard bench for gcm_out_stream: directed blocks, backpressure, full/overflow, reset.
module tb_gcm_out_stream;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] gcm_out_blk = '0;
  logic         gcm_out_store_blk = 1'b0;
  logic         gcm_out_last = 1'b0;
  logic         hold_off;
  logic [31:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic         m_axis_tlast;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [32:0] sb[$];

  always #5 clk = ~clk;

  gcm_out_stream #(
    .FIFO_DEPTH (4),
    .OUT_BITS   (32)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .gcm_out_blk       (gcm_out_blk),
    .gcm_out_store_blk (gcm_out_store_blk),
    .gcm_out_last      (gcm_out_last),
    .hold_off          (hold_off),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast),
    .overflow          (overflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef GCM_OUT_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic push_words(input logic [127:0] blk, input logic last, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = blk[127 - 32*i -: 32];
      sb.push_back({last && (i == 3), exp_word(w)});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a single-cycle strobe; consecutive calls give back-to-back strobes.
  task automatic strobe(input logic [127:0] blk, input logic last);
    gcm_out_blk       = blk;
    gcm_out_last      = last;
    gcm_out_store_blk = 1'b1;
    step();
    gcm_out_store_blk = 1'b0;
    gcm_out_last      = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !m_axis_tvalid) done = 1;
    end
    chk({name, "_drained"}, 64'(done), 64'd1);
    chk({name, "_sb_left"}, 64'(sb.size()), 64'd0);
    step();
  endtask

  // Monitor: pops the scoreboard on each handshake and checks stability during stalls.
  initial begin
    logic        prev_stall = 1'b0;
    logic [32:0] prev = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
          chk("stall_tdata_tlast", 64'({m_axis_tlast, m_axis_tdata}), 64'(prev));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got %h expected none", {m_axis_tlast, m_axis_tdata});
          end else begin
            logic [32:0] e;
            e = sb.pop_front();
            chk("word", 64'({m_axis_tlast, m_axis_tdata}), 64'(e));
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev       = {m_axis_tlast, m_axis_tdata};
      end
    end
  end

  localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK_B = 128'h01020304_05060708_090A0B0C_0D0E0F10;
  localparam logic [127:0] BLK_C = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
  localparam logic [127:0] BLK_D = 128'hA5A5A5A5_5A5A5A5A_FFFFFFFF_00000000;
  localparam logic [127:0] BLK_E = 128'h11111111_22222222_33333333_44444444;

  initial begin
    logic [3:0] pat;
    pat = 4'b1001;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_hold_off", 64'(hold_off), 64'd0);
    step();

    // Single block, tready high, one-cycle latency to word 0
    m_axis_tready = 1'b1;
    push_words(BLK_A, 1'b1, 4);
    strobe(BLK_A, 1'b1);
    @(negedge clk);
    chk("latency_tvalid", 64'(m_axis_tvalid), 64'd1);
`ifdef GCM_OUT_BYTESWAP_EN
    chk("byteswap_word0", 64'(m_axis_tdata), 64'h33221100);
`else
    chk("latency_word0", 64'(m_axis_tdata), 64'h00112233);
`endif
    wait_drain("single");

    // Backpressure: tready 1,0,0,1 over three blocks
    m_axis_tready = 1'b0;
    push_words(BLK_B, 1'b0, 4);
    push_words(BLK_C, 1'b0, 4);
    push_words(BLK_D, 1'b1, 4);
    strobe(BLK_B, 1'b0);
    strobe(BLK_C, 1'b0);
    strobe(BLK_D, 1'b1);
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      m_axis_tready = pat[i % 4];
      step();
    end
    m_axis_tready = 1'b1;
    wait_drain("backpressure");

    // Full and overflow: five strobes into a stalled DEPTH=4 FIFO
    m_axis_tready = 1'b0;
    push_words(BLK_A, 1'b0, 4);
    push_words(BLK_B, 1'b0, 4);
    push_words(BLK_C, 1'b0, 4);
    push_words(BLK_D, 1'b1, 4);
    strobe(BLK_A, 1'b0);
    strobe(BLK_B, 1'b0);
    @(negedge clk);
    chk("hold_off_after2", 64'(hold_off), 64'd0);
    step();
    strobe(BLK_C, 1'b0);
    @(negedge clk);
    chk("hold_off_after3", 64'(hold_off), 64'd1);
    step();
    strobe(BLK_D, 1'b1);
    @(negedge clk);
    chk("overflow_after4", 64'(overflow), 64'd0);
    step();
    strobe(BLK_E, 1'b1);
    @(negedge clk);
    chk("overflow_after5", 64'(overflow), 64'd1);
    step();
    m_axis_tready = 1'b1;
    wait_drain("full");
    chk("overflow_sticky", 64'(overflow), 64'd1);
    chk("hold_off_empty", 64'(hold_off), 64'd0);

    // Simultaneous push/pop at full
    do_reset();
    m_axis_tready = 1'b0;
    push_words(BLK_A, 1'b0, 4);
    push_words(BLK_B, 1'b0, 4);
    push_words(BLK_C, 1'b0, 4);
    push_words(BLK_D, 1'b0, 4);
    push_words(BLK_E, 1'b1, 4);
    strobe(BLK_A, 1'b0);
    strobe(BLK_B, 1'b0);
    strobe(BLK_C, 1'b0);
    strobe(BLK_D, 1'b0);
    m_axis_tready = 1'b1;
    step();
    step();
    step();
    strobe(BLK_E, 1'b1);
    @(negedge clk);
    chk("pushpop_overflow", 64'(overflow), 64'd0);
    chk("pushpop_hold_off", 64'(hold_off), 64'd1);
    step();
    wait_drain("pushpop");
    chk("pushpop_overflow_end", 64'(overflow), 64'd0);

    // Reset mid-block: only words 0 and 1 of A go out, strobe during reset ignored
    m_axis_tready = 1'b1;
    push_words(BLK_A, 1'b0, 2);
    strobe(BLK_A, 1'b0);
    step();
    step();
    reset             = 1'b1;
    gcm_out_blk       = BLK_C;
    gcm_out_store_blk = 1'b1;
    step();
    reset             = 1'b0;
    gcm_out_store_blk = 1'b0;
    @(negedge clk);
    chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("midrst_tlast", 64'(m_axis_tlast), 64'd0);
    step();
    push_words(BLK_B, 1'b1, 4);
    strobe(BLK_B, 1'b1);
    wait_drain("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gcm_out_stream.md
GCM_OUT_STREAM -- requirements
Module: gcm_out_stream

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of 128-bit blocks buffered (power of two, 2..16).
REQ-002 SHALL have parameter OUT_BITS, default 32, meaning the output stream word width (fixed 32).
REQ-003 SHALL have port clk, input, 1 bit: clock; all logic rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port gcm_out_blk, input, 128 bits: ciphertext/plaintext or tag block from the GCM core.
REQ-006 SHALL have port gcm_out_store_blk, input, 1 bit: single-cycle strobe; the block is valid this cycle; no backpressure.
REQ-007 SHALL have port gcm_out_last, input, 1 bit: qualifies the strobe; the block is the final block (tag) of a message.
REQ-008 SHALL have port hold_off, output, 1 bit: high when free slots are below 2; upstream stops issuing new blocks.
REQ-009 SHALL have ports m_axis_tdata (output, 32 bits), m_axis_tvalid (output, 1 bit), m_axis_tready (input, 1 bit) and m_axis_tlast (output, 1 bit), forming an AXI4-Stream master.
REQ-010 SHALL have port overflow, output, 1 bit: sticky error flag, set when a strobe arrives while the FIFO is full.

Function
REQ-011 SHALL write {gcm_out_last, gcm_out_blk} into the block FIFO on every strobe cycle while the FIFO is not full.
REQ-012 SHALL drop a strobe that arrives when the FIFO is full, set overflow, and leave the FIFO contents unchanged.
REQ-013 SHALL serialise each block into 4 words, most-significant first: [127:96], [95:64], [63:32], [31:0].
REQ-014 SHALL use a 2-bit word counter that advances only on tvalid && tready; the block is popped when the counter wraps from 3 to 0.
REQ-015 SHALL hold tvalid high exactly while the FIFO is non-empty.
REQ-016 SHALL hold tdata, tlast and tvalid stable while tvalid && !tready.
REQ-017 SHALL assert tlast only on word 3 of a block stored with the last flag set.
REQ-018 SHALL latency: a strobe into an empty FIFO produces tvalid=1 with word 0 on the following cycle (one cycle).
REQ-019 SHALL allow a push and a pop in the same cycle, including when the FIFO is full; the count is unchanged and the strobe is accepted, not dropped.
REQ-020 SHALL wrap read and write pointers modulo FIFO_DEPTH; the occupancy count is $clog2(FIFO_DEPTH)+1 bits wide.
REQ-021 SHALL compute hold_off combinationally from the occupancy count: hold_off = (FIFO_DEPTH - count) < 2.
REQ-022 SHALL sustain one word per cycle with tready held high, so one block is emitted every 4 cycles.

Reset
REQ-023 SHALL on reset clear pointers, count and word counter, and drive tvalid=0, tlast=0, overflow=0, hold_off=0; tdata is don't-care.
REQ-024 SHALL on reset mid-block discard all buffered and partially sent blocks; a strobe in the reset cycle is ignored.
REQ-025 SHALL clear overflow only by reset.

Configuration
REQ-026 SHALL, with GCM_OUT_BYTESWAP_EN defined, reverse the byte order within each 32-bit output word (tdata[7:0] <= word[31:24], and so on) for little-endian DMA.
REQ-027 SHALL, without GCM_OUT_BYTESWAP_EN defined, output each word unswapped; no other behaviour changes in either case.

Structure
REQ-028 SHALL take GCM_BLK_BITS (128) and OUT_BITS (32) from shared package gcm_pkg, which also defines the FIFO entry struct {last, blk}.
REQ-029 SHALL instantiate one sub-module gcm_blk_fifo: a synchronous FIFO with push, pop, full, empty and count; serialisation stays in the top module.

Verification
REQ-030 SHALL cover single block: strobe with blk=0x00112233_44556677_8899AABB_CCDDEEFF, last=1, tready=1 -> words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on consecutive cycles, tlast on the 4th word only.
REQ-031 SHALL cover backpressure: tready toggled 1,0,0,1,... -> tdata and tlast stable during stalls, with no lost or duplicated word across 3 blocks.
REQ-032 SHALL cover full and overflow: DEPTH=4, tready=0, 5 strobes -> hold_off high after the 3rd strobe, overflow=1 after the 5th, and exactly the first 4 blocks emitted once tready=1.
REQ-033 SHALL cover simultaneous push/pop at full: the strobe on the same cycle as the final-word handshake -> accepted, overflow stays 0.
REQ-034 SHALL cover reset mid-block: reset after word 1 of block A -> tvalid=0 on the next cycle, and a subsequent block B starts at word 0.
REQ-035 SHALL cover byteswap: with GCM_OUT_BYTESWAP_EN defined, word 0x00112233 -> tdata 0x33221100.
